pc_sequencer: RTL and testbench

- Owns the fetch PC register of the 5-stage MIPS pipeline and decides the next PC every cycle.
- Arbitrates between sequential fetch, ID-stage branch/jump/jr redirects, exception entry and eret.
- Honours IF stalls.
- Provides PC+4 and the PC+8 link address (branch delay slot) to the IF/ID register.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage MIPS pipeline: picks sequential, redirect,
// exception or eret next-PC each cycle and parks redirects that arrive during a stall.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        j_valid_i,
    input  logic [31:0] j_target_i,
    input  logic        jr_valid_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_plus8_o,
    output logic        flush_o,
    output logic        pending_o,
    output logic        addr_err_o
);

    typedef enum logic {RUN, PEND} state_t;

    // Source codes ordered so a numerically larger code means higher priority.
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_J    = 3'd2;
    localparam logic [2:0] SRC_JR   = 3'd3;
    localparam logic [2:0] SRC_ERET = 3'd4;

    state_t      state, state_nxt;
    logic [31:0] pc_r, pc_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic [2:0]  pend_src, pend_src_nxt;
    logic        flush_nxt, aerr_nxt;

    logic [31:0] tgt;
    logic [2:0]  src;
    logic        redir;

    // Exception is handled separately; tgt/src cover the remaining redirects.
    always_comb begin
        tgt = 32'd0;
        src = SRC_NONE;
        if (eret_i) begin
            tgt = epc_i;
            src = SRC_ERET;
        end else if (jr_valid_i) begin
            tgt = jr_target_i;
            src = SRC_JR;
        end else if (j_valid_i) begin
            tgt = j_target_i;
            src = SRC_J;
        end else if (br_taken_i) begin
            tgt = br_target_i;
            src = SRC_BR;
        end
    end

    assign redir = exc_req_i | (src != SRC_NONE);

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc_r;
        pend_target_nxt = pend_target;
        pend_src_nxt    = pend_src;
        flush_nxt       = 1'b0;
        aerr_nxt        = 1'b0;
        if (exc_req_i) begin
            pc_nxt          = EXC_VECTOR;
            flush_nxt       = 1'b1;
            pend_target_nxt = 32'd0;
            pend_src_nxt    = SRC_NONE;
            state_nxt       = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (redir && !stall_i) begin
                        pc_nxt   = {tgt[31:2], 2'b00};
                        aerr_nxt = |tgt[1:0];
                    end else if (redir) begin
                        pend_target_nxt = tgt;
                        pend_src_nxt    = src;
                        state_nxt       = PEND;
                    end else if (!stall_i) begin
                        pc_nxt = pc_r + 32'd4;
                    end
                end
                PEND: begin
                    if (!stall_i) begin
                        // A strictly higher-priority redirect on the release cycle wins.
                        if (src > pend_src) begin
                            pc_nxt   = {tgt[31:2], 2'b00};
                            aerr_nxt = |tgt[1:0];
                        end else begin
                            pc_nxt   = {pend_target[31:2], 2'b00};
                            aerr_nxt = |pend_target[1:0];
                        end
                        pend_target_nxt = 32'd0;
                        pend_src_nxt    = SRC_NONE;
                        state_nxt       = RUN;
                    end else if (src > pend_src) begin
                        pend_target_nxt = tgt;
                        pend_src_nxt    = src;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_r        <= RESET_PC;
            pend_target <= 32'd0;
            pend_src    <= SRC_NONE;
            flush_o     <= 1'b0;
            addr_err_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc_r        <= pc_nxt;
            pend_target <= pend_target_nxt;
            pend_src    <= pend_src_nxt;
            flush_o     <= flush_nxt;
            addr_err_o  <= aerr_nxt;
        end
    end

    assign pc_o       = pc_r;
    assign pc_plus4_o = pc_r + 32'd4;
    assign pc_plus8_o = pc_r + 32'd8;
    assign pending_o  = (state == PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expected PCs and pulses.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        j_valid_i;
    logic [31:0] j_target_i;
    logic        jr_valid_i;
    logic [31:0] jr_target_i;
    logic        exc_req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o, pc_plus4_o, pc_plus8_o;
    logic        flush_o, pending_o, addr_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall_i),
        .br_taken_i (br_taken_i),
        .br_target_i(br_target_i),
        .j_valid_i  (j_valid_i),
        .j_target_i (j_target_i),
        .jr_valid_i (jr_valid_i),
        .jr_target_i(jr_target_i),
        .exc_req_i  (exc_req_i),
        .eret_i     (eret_i),
        .epc_i      (epc_i),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .pc_plus8_o (pc_plus8_o),
        .flush_o    (flush_o),
        .pending_o  (pending_o),
        .addr_err_o (addr_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0;
        br_taken_i = 1'b0; br_target_i = '0;
        j_valid_i = 1'b0;  j_target_i = '0;
        jr_valid_i = 1'b0; jr_target_i = '0;
        exc_req_i = 1'b0;  eret_i = 1'b0; epc_i = '0;
        step(); step();
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_pend", {31'd0, pending_o}, 32'd0);
        chk("rst_aerr", {31'd0, addr_err_o}, 32'd0);
        reset = 1'b0;

        step(); chk("seq1", pc_o, 32'h3004);
        step(); chk("seq2", pc_o, 32'h3008);
        step(); chk("seq3", pc_o, 32'h300C);
        chk("seq_p4", pc_plus4_o, 32'h3010);
        chk("seq_p8", pc_plus8_o, 32'h3014);
        chk("seq_flush", {31'd0, flush_o}, 32'd0);

        // taken branch, no stall
        br_taken_i = 1'b1; br_target_i = 32'h3100;
        step();
        chk("br_pc", pc_o, 32'h3100);
        chk("br_flush", {31'd0, flush_o}, 32'd0);
        chk("br_pend", {31'd0, pending_o}, 32'd0);
        br_taken_i = 1'b0;

        // jump captured under a 3-cycle stall
        stall_i = 1'b1; j_valid_i = 1'b1; j_target_i = 32'h3200;
        step();
        chk("st1_pc", pc_o, 32'h3100);
        chk("st1_pend", {31'd0, pending_o}, 32'd1);
        j_valid_i = 1'b0;
        step(); chk("st2_pend", {31'd0, pending_o}, 32'd1);
        step(); chk("st3_pc", pc_o, 32'h3100);
        chk("st3_pend", {31'd0, pending_o}, 32'd1);
        stall_i = 1'b0;
        step();
        chk("rel_pc", pc_o, 32'h3200);
        chk("rel_pend", {31'd0, pending_o}, 32'd0);

        // br pending, jr overrides, later br ignored
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h3100;
        step();
        br_taken_i = 1'b0; jr_valid_i = 1'b1; jr_target_i = 32'h3300;
        step();
        jr_valid_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h3100;
        step();
        chk("prio_hold", pc_o, 32'h3200);
        br_taken_i = 1'b0; stall_i = 1'b0;
        step();
        chk("prio_pc", pc_o, 32'h3300);

        // exception while pending and stalled
        stall_i = 1'b1; jr_valid_i = 1'b1; jr_target_i = 32'h3400;
        step();
        chk("exc_pre_pend", {31'd0, pending_o}, 32'd1);
        exc_req_i = 1'b1;
        step();
        chk("exc_pc", pc_o, 32'h4180);
        chk("exc_flush", {31'd0, flush_o}, 32'd1);
        chk("exc_pend", {31'd0, pending_o}, 32'd0);
        exc_req_i = 1'b0; jr_valid_i = 1'b0; stall_i = 1'b0;
        step();
        chk("exc_flush_end", {31'd0, flush_o}, 32'd0);
        chk("exc_seq", pc_o, 32'h4184);
        eret_i = 1'b1; epc_i = 32'h3008;
        step();
        chk("eret_pc", pc_o, 32'h3008);
        eret_i = 1'b0;

        // back-to-back exceptions
        exc_req_i = 1'b1;
        step(); chk("b2b_flush1", {31'd0, flush_o}, 32'd1);
        step(); chk("b2b_flush2", {31'd0, flush_o}, 32'd1);
        chk("b2b_pc", pc_o, 32'h4180);
        exc_req_i = 1'b0;
        step(); chk("b2b_flush3", {31'd0, flush_o}, 32'd0);

        // misaligned jump target
        j_valid_i = 1'b1; j_target_i = 32'h3202;
        step();
        chk("mis_pc", pc_o, 32'h3200);
        chk("mis_aerr", {31'd0, addr_err_o}, 32'd1);
        j_valid_i = 1'b0;
        step();
        chk("mis_aerr_end", {31'd0, addr_err_o}, 32'd0);
        chk("mis_seq", pc_o, 32'h3204);

        // wrap-around
        j_valid_i = 1'b1; j_target_i = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4_o, 32'h0000_0000);
        chk("wrap_p8", pc_plus8_o, 32'h0000_0004);
        j_valid_i = 1'b0;
        step();
        chk("wrap_next", pc_o, 32'h0000_0000);

        // reset in PEND discards the captured target
        stall_i = 1'b1; j_valid_i = 1'b1; j_target_i = 32'h5000;
        step();
        chk("rp_pend", {31'd0, pending_o}, 32'd1);
        j_valid_i = 1'b0; reset = 1'b1;
        step();
        chk("rp_pc", pc_o, 32'h3000);
        chk("rp_pend_clr", {31'd0, pending_o}, 32'd0);
        reset = 1'b0; stall_i = 1'b0;
        step();
        chk("rp_seq", pc_o, 32'h3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
